// File: rtl/calo_pkg.sv
// Shared calorimeter grid constants, tower record and readout FSM states.
// The tower store is addressed linearly as eta + phi * 2**ETA_BITS.
package calo_pkg;
  localparam int ETA_BITS  = 5;
  localparam int PHI_BITS  = 5;
  localparam int DATA_W    = 8;
  localparam int SUM_W     = 18;
  localparam int GRID_SIZE = 1 << (ETA_BITS + PHI_BITS);

  typedef struct packed {
    logic [ETA_BITS-1:0] eta;
    logic [PHI_BITS-1:0] phi;
    logic [DATA_W-1:0]   et;
    logic [DATA_W-1:0]   e;
  } tower_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/grid_addr_ctr.sv
// Nested eta/phi address counter: eta is the inner digit, phi the outer.
// last is high while the counter sits on the final cell of the grid.
module grid_addr_ctr #(
  parameter int ETA_BITS = 5,
  parameter int PHI_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  output logic [ETA_BITS-1:0] eta,
  output logic [PHI_BITS-1:0] phi,
  output logic                last
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eta <= '0;
      phi <= '0;
    end else if (clear) begin
      eta <= '0;
      phi <= '0;
    end else if (inc) begin
      if (&eta) begin
        eta <= '0;
        phi <= phi + 1'b1;
      end else begin
        eta <= eta + 1'b1;
      end
    end
  end

  assign last = (&eta) & (&phi);
endmodule

// File: rtl/tower_scan.sv
// Sweeps the tower store grid, streams towers at/above threshold, and
// publishes scan-wide et sum and maximum tower when the sweep completes.
module tower_scan #(
  parameter int ETA_BITS = calo_pkg::ETA_BITS,
  parameter int PHI_BITS = calo_pkg::PHI_BITS,
  parameter int DATA_W   = calo_pkg::DATA_W,
  parameter int SUM_W    = calo_pkg::SUM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   threshold,
  output logic                rd_en,
  output logic [ETA_BITS-1:0] rd_eta,
  output logic [PHI_BITS-1:0] rd_phi,
  input  logic [DATA_W-1:0]   rd_et,
  input  logic [DATA_W-1:0]   rd_e,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ETA_BITS-1:0] out_eta,
  output logic [PHI_BITS-1:0] out_phi,
  output logic [DATA_W-1:0]   out_et,
  output logic [DATA_W-1:0]   out_e,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    sum_et,
  output logic [DATA_W-1:0]   max_et,
  output logic [ETA_BITS-1:0] max_eta,
  output logic [PHI_BITS-1:0] max_phi,
  output logic [2:0]          fsm_state
);
  import calo_pkg::*;

  // Hit stream: a transfer happens on every rising edge with out_valid && out_ready;
  // out_valid and the payload hold steady until that transfer (or reset).
  state_t            state;
  tower_t            cell_q;
  tower_t            max_q;
  logic [DATA_W-1:0] thr_q;
  logic [SUM_W-1:0]  sum_q;
  logic              hit;
  logic              adv;
  logic              last;

  assign hit = (rd_et >= thr_q);
  assign adv = ((state == S_WAIT) && !hit) || ((state == S_EMIT) && out_ready);

  grid_addr_ctr #(
    .ETA_BITS(ETA_BITS),
    .PHI_BITS(PHI_BITS)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clear((state == S_IDLE) && start),
    .inc  (adv && !last),
    .eta  (rd_eta),
    .phi  (rd_phi),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      thr_q     <= '0;
      cell_q    <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            thr_q <= threshold;
            sum_q <= '0;
            max_q <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          cell_q <= '{eta: rd_eta, phi: rd_phi, et: rd_et, e: rd_e};
          sum_q  <= sum_q + SUM_W'(rd_et);
          // Strict compare: on ties the earlier tower in scan order wins.
          if (rd_et > max_q.et)
            max_q <= '{eta: rd_eta, phi: rd_phi, et: rd_et, e: rd_e};
          if (hit) begin
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end else if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_en <= 1'b1;
            state <= S_READ;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rd_en <= 1'b1;
              state <= S_READ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_eta   = cell_q.eta;
  assign out_phi   = cell_q.phi;
  assign out_et    = cell_q.et;
  assign out_e     = cell_q.e;
  assign sum_et    = sum_q;
  assign max_et    = max_q.et;
  assign max_eta   = max_q.eta;
  assign max_phi   = max_q.phi;
  assign fsm_state = state;
endmodule

// File: tb/tb_tower_scan.sv
// Directed bench for tower_scan: a registered tower-store model feeds the
// read port, and a scoreboard queue holds the hits expected in scan order.
module tb_tower_scan;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  threshold;
  logic        rd_en;
  logic [4:0]  rd_eta;
  logic [4:0]  rd_phi;
  logic [7:0]  rd_et;
  logic [7:0]  rd_e;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_eta;
  logic [4:0]  out_phi;
  logic [7:0]  out_et;
  logic [7:0]  out_e;
  logic        busy;
  logic        done;
  logic [17:0] sum_et;
  logic [7:0]  max_et;
  logic [4:0]  max_eta;
  logic [4:0]  max_phi;
  logic [2:0]  fsm_state;

  logic [7:0]  et_mem[1024];
  logic [7:0]  e_mem[1024];
  logic [25:0] exp_q[$];

  int n_checks;
  int n_pass;
  int scan_busy;
  int scan_done_cyc;
  int scan_hits;
  int exp_sum;
  int exp_max;
  int exp_max_idx;

  tower_scan dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .rd_en(rd_en), .rd_eta(rd_eta), .rd_phi(rd_phi), .rd_et(rd_et), .rd_e(rd_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_eta(out_eta), .out_phi(out_phi),
    .out_et(out_et), .out_e(out_e), .busy(busy), .done(done), .sum_et(sum_et),
    .max_et(max_et), .max_eta(max_eta), .max_phi(max_phi), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tower store: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) begin
      rd_et <= et_mem[{rd_phi, rd_eta}];
      rd_e  <= e_mem[{rd_phi, rd_eta}];
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      et_mem[i] = 8'd0;
      e_mem[i]  = 8'd0;
    end
  endtask

  // Reference model: expected hit list, sum and max (first tower wins ties).
  task automatic build_expect(input logic [7:0] thr);
    exp_q.delete();
    exp_sum = 0;
    exp_max = 0;
    exp_max_idx = 0;
    for (int p = 0; p < 32; p++) begin
      for (int e = 0; e < 32; e++) begin
        int idx;
        idx = e + p * 32;
        exp_sum += int'(et_mem[idx]);
        if (int'(et_mem[idx]) > exp_max) begin
          exp_max = int'(et_mem[idx]);
          exp_max_idx = idx;
        end
        if (et_mem[idx] >= thr) exp_q.push_back({5'(e), 5'(p), et_mem[idx], e_mem[idx]});
      end
    end
  endtask

  // ready_mode 1: always ready; 2: pseudo-random ready. mid_start pulses start mid-scan.
  task automatic run_scan(input logic [7:0] thr, input int ready_mode, input bit mid_start);
    int cyc;
    bit prev_stall;
    logic [25:0] prev_pay;
    logic [25:0] act;
    logic [25:0] exp_v;
    build_expect(thr);
    scan_busy = 0;
    scan_done_cyc = 0;
    scan_hits = 0;
    prev_stall = 1'b0;
    prev_pay = '0;
    out_ready = 1'b1;
    @(negedge clk);
    threshold = thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    n_checks++;
    if (rd_en === 1'b1 && rd_eta === 5'd0 && rd_phi === 5'd0) n_pass++;
    else $display("FAIL first_read: rd_en=%0b eta=%0d phi=%0d, required 1 at (0,0)", rd_en, rd_eta, rd_phi);
    while (1) begin
      if (busy) scan_busy++;
      if (done) begin
        scan_done_cyc = cyc;
        break;
      end
      if (cyc >= 12000) break;
      if (mid_start) begin
        start = (cyc == 300);
        if (cyc == 300) threshold = 8'd0;
      end
      act = {out_eta, out_phi, out_et, out_e};
      if (prev_stall) begin
        n_checks++;
        if (out_valid === 1'b1 && act === prev_pay) n_pass++;
        else $display("FAIL stall_hold: valid=%0b payload=%h, required 1 %h", out_valid, act, prev_pay);
      end
      out_ready = (ready_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        scan_hits++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3ffffff;
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL hit_payload: got %h, required %h (hit %0d)", act, exp_v, scan_hits);
      end
      prev_stall = out_valid && !out_ready;
      prev_pay = act;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (scan_done_cyc != 0) n_pass++;
    else $display("FAIL scan_timeout: no done within %0d cycles, required done", cyc);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL hits_missing: %0d expected hits left, required 0", exp_q.size());
    @(negedge clk);
    n_checks++;
    if (done === 1'b0 && busy === 1'b0) n_pass++;
    else $display("FAIL done_pulse: done=%0b busy=%0b after pulse, required 0 0", done, busy);
    if (mid_start) threshold = thr;
  endtask

  task automatic check_summary(input string name, input int s, input int m, input int idx);
    n_checks++;
    if (sum_et === 18'(s)) n_pass++;
    else $display("FAIL %s_sum: got %0d, required %0d", name, sum_et, s);
    n_checks++;
    if (max_et === 8'(m) && max_eta === 5'(idx % 32) && max_phi === 5'(idx / 32)) n_pass++;
    else $display("FAIL %s_max: got %0d at (%0d,%0d), required %0d at (%0d,%0d)",
                  name, max_et, max_eta, max_phi, m, idx % 32, idx / 32);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    threshold = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fsm_state === 3'd0 && busy === 1'b0 && done === 1'b0 && rd_en === 1'b0) n_pass++;
    else $display("FAIL reset_ctrl: state=%0d busy=%0b done=%0b rd_en=%0b, required 0 0 0 0",
                  fsm_state, busy, done, rd_en);
    n_checks++;
    if (out_valid === 1'b0 && {out_eta, out_phi, out_et, out_e} === 26'd0) n_pass++;
    else $display("FAIL reset_out: valid=%0b payload=%h, required 0 0", out_valid,
                  {out_eta, out_phi, out_et, out_e});
    n_checks++;
    if (sum_et === 18'd0 && max_et === 8'd0 && max_eta === 5'd0 && max_phi === 5'd0) n_pass++;
    else $display("FAIL reset_summary: sum=%0d max=%0d (%0d,%0d), required 0", sum_et, max_et, max_eta, max_phi);
  endtask

  task automatic test_all_zero();
    clear_mem();
    run_scan(8'd1, 1, 1'b0);
    n_checks++;
    if (scan_done_cyc == 2050) n_pass++;
    else $display("FAIL zero_done_cycle: got %0d, required 2050", scan_done_cyc);
    n_checks++;
    if (scan_busy == 2048) n_pass++;
    else $display("FAIL zero_busy_cycles: got %0d, required 2048", scan_busy);
    n_checks++;
    if (scan_hits == 0) n_pass++;
    else $display("FAIL zero_hits: got %0d, required 0", scan_hits);
    check_summary("zero", 0, 0, 0);
  endtask

  task automatic test_single();
    clear_mem();
    et_mem[7 + 3 * 32] = 8'd200;
    e_mem[7 + 3 * 32]  = 8'd77;
    run_scan(8'd50, 1, 1'b0);
    n_checks++;
    if (scan_hits == 1) n_pass++;
    else $display("FAIL single_hits: got %0d, required 1", scan_hits);
    n_checks++;
    if (scan_done_cyc == 2051) n_pass++;
    else $display("FAIL single_done_cycle: got %0d, required 2051", scan_done_cyc);
    check_summary("single", 200, 200, 7 + 3 * 32);
  endtask

  task automatic test_ties();
    clear_mem();
    et_mem[0] = 8'd9;
    e_mem[0] = 8'd21;
    et_mem[1023] = 8'd9;
    e_mem[1023] = 8'd42;
    for (int i = 1; i < 1023; i++) e_mem[i] = 8'(i * 7);
    run_scan(8'd0, 1, 1'b0);
    n_checks++;
    if (scan_hits == 1024) n_pass++;
    else $display("FAIL ties_hits: got %0d, required 1024", scan_hits);
    check_summary("ties", 18, 9, 0);
  endtask

  task automatic test_all_max();
    for (int i = 0; i < 1024; i++) begin
      et_mem[i] = 8'd255;
      e_mem[i]  = 8'(i);
    end
    run_scan(8'd255, 1, 1'b0);
    n_checks++;
    if (scan_hits == 1024) n_pass++;
    else $display("FAIL full_hits: got %0d, required 1024", scan_hits);
    check_summary("full", 261120, 255, 0);
  endtask

  task automatic test_back_to_back_stall();
    for (int i = 0; i < 1024; i++) begin
      et_mem[i] = 8'($urandom_range(0, 255));
      e_mem[i]  = 8'($urandom_range(0, 255));
    end
    run_scan(8'd128, 2, 1'b1);
    n_checks++;
    if (scan_hits == int'(exp_q.size()) + scan_hits && scan_done_cyc > 2050) n_pass++;
    else $display("FAIL stall_scan_len: done at %0d, required > 2050", scan_done_cyc);
    check_summary("stall", exp_sum, exp_max, exp_max_idx);
  endtask

  task automatic test_reset_mid_emit();
    int waited;
    bit saw_done;
    clear_mem();
    et_mem[5 + 2 * 32] = 8'd100;
    e_mem[5 + 2 * 32]  = 8'd33;
    et_mem[6]          = 8'd250;
    @(negedge clk);
    out_ready = 1'b0;
    threshold = 8'd90;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (out_valid === 1'b1 && out_et === 8'd250) n_pass++;
    else $display("FAIL emit_reached: valid=%0b et=%0d, required 1 250", out_valid, out_et);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid === 1'b0 && busy === 1'b0 && done === 1'b0 && rd_en === 1'b0 &&
        sum_et === 18'd0 && max_et === 8'd0 && out_et === 8'd0 && fsm_state === 3'd0) n_pass++;
    else $display("FAIL abort_outputs: valid=%0b busy=%0b done=%0b sum=%0d max=%0d et=%0d, required all 0",
                  out_valid, busy, done, sum_et, max_et, out_et);
    rst = 1'b0;
    out_ready = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1'b1;
    end
    n_checks++;
    if (!saw_done) n_pass++;
    else $display("FAIL abort_quiet: done or out_valid seen after abort, required none");
    run_scan(8'd90, 1, 1'b0);
    n_checks++;
    if (scan_hits == 2) n_pass++;
    else $display("FAIL rescan_hits: got %0d, required 2", scan_hits);
    check_summary("rescan", 350, 250, 6);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rd_et = 8'd0;
    rd_e = 8'd0;
    clear_mem();
    test_reset();
    test_all_zero();
    test_single();
    test_ties();
    test_all_max();
    test_back_to_back_stall();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
